// File: rtl/adc_uart_reporter.sv
// adc_uart_reporter: periodically requests a measurement from the BCD/ASCII
// conversion stage, latches the ASCII digit word and sends it as a text line
// such as "1.234 V\r\n" over a UART 8N1 transmitter.
`timescale 1ns / 1ps

module adc_uart_reporter #(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned DP_POS        = 3,
  parameter int unsigned PERIOD_CYCLES = 10_000_000,
  parameter logic [7:0]  UNIT_CHAR     = 8'h56
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bcd_end,
  input  logic [NUM_DIGITS*8-1:0] ascii_digits,
  output logic                    bcd_start,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned BAUD_DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HAS_DP     = (DP_POS > 0) ? 1 : 0;
  localparam int unsigned INT_DIGITS = NUM_DIGITS - DP_POS;
  localparam int unsigned FRAME_LEN  = NUM_DIGITS + HAS_DP + 4;
  localparam int unsigned PER_W      = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned BAUD_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IDX_W      = $clog2(FRAME_LEN);

  localparam logic [PER_W-1:0]  PERIOD_LAST = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(FRAME_LEN - 1);
  localparam logic [3:0]        STOP_BIT    = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_SEND,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [PER_W-1:0]        period_q, period_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [3:0]              bit_q, bit_d;
  logic [IDX_W-1:0]        char_idx_q, char_idx_d;
  logic [8:0]              shift_q, shift_d;
  logic [NUM_DIGITS*8-1:0] digits_q, digits_d;
  logic                    tx_q, tx_d;
  logic                    bcd_start_q, bcd_start_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    tick;

  // Text line as a byte table: digits with optional point, then " <unit>\r\n".
  logic [7:0] frame_bytes [FRAME_LEN];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digits
    localparam int unsigned POS = (HAS_DP != 0 && k >= INT_DIGITS) ? k + 1 : k;
    assign frame_bytes[POS] = digits_q[(NUM_DIGITS-1-k)*8 +: 8];
  end

  if (HAS_DP != 0) begin : g_point
    assign frame_bytes[INT_DIGITS] = 8'h2E;
  end

  assign frame_bytes[NUM_DIGITS+HAS_DP]     = 8'h20;
  assign frame_bytes[NUM_DIGITS+HAS_DP + 1] = UNIT_CHAR;
  assign frame_bytes[NUM_DIGITS+HAS_DP + 2] = 8'h0D;
  assign frame_bytes[NUM_DIGITS+HAS_DP + 3] = 8'h0A;

  // Next-state logic for the period timer, request handshake and UART shifter.
  always_comb begin
    // NOTE: every _d starts from its _q value so no branch can leave a latch behind.
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    char_idx_d   = char_idx_q;
    shift_d      = shift_q;
    digits_d     = digits_q;
    tx_d         = tx_q;
    bcd_start_d  = bcd_start_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    tick     = (period_q == PERIOD_LAST);
    period_d = tick ? '0 : period_q + PER_W'(1);

    unique case (state_q)
      S_IDLE: begin
        // Ticks seen in any other state are simply lost.
        if (tick) begin
          state_d     = S_REQ;
          bcd_start_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_REQ: begin
        if (bcd_end) begin
          digits_d    = ascii_digits;
          bcd_start_d = 1'b0;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!bcd_end) begin
          char_idx_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        // Start bit goes out on the next edge; shift holds {stop, data}.
        shift_d = {1'b1, frame_bytes[char_idx_q]};
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == STOP_BIT) begin
            if (char_idx_q == IDX_LAST) begin
              state_d      = S_DONE;
              busy_d       = 1'b0;
              frame_done_d = 1'b1;
            end else begin
              char_idx_d = char_idx_q + IDX_W'(1);
              state_d    = S_SEND;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register all state; reset aborts any frame and forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      period_q     <= '0;
      baud_q       <= '0;
      bit_q        <= '0;
      char_idx_q   <= '0;
      shift_q      <= '1;
      digits_q     <= '0;
      tx_q         <= 1'b1;
      bcd_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      char_idx_q   <= char_idx_d;
      shift_q      <= shift_d;
      digits_q     <= digits_d;
      tx_q         <= tx_d;
      bcd_start_q  <= bcd_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd_start  = bcd_start_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
